// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, state encoding and the access-legality check
//               used by the data-memory arbiter.
//               dmctrl_e : data_memory access-width encoding (RISC-V funct3).
//               state_t  : arbiter sequencer state (ST_IDLE, ST_RESP).
//               dm_access_err() : 1 when an access must not reach memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_e;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;

    // Returns 1 for an illegal width, a misaligned H/W access, an access whose
    // last byte lies at or beyond mem_bytes, or an unsigned-width store.
    // The address is widened so addr+size can never wrap.
    function automatic logic dm_access_err(
        input logic [63:0]  addr,
        input logic [2:0]   ctrl,
        input logic         we,
        input int unsigned  mem_bytes
    );
        logic [64:0] size;
        logic        bad;
        bad  = 1'b0;
        size = 65'd4;
        case (ctrl)
            DM_B, DM_BU: size = 65'd1;
            DM_H, DM_HU: begin
                size = 65'd2;
                bad  = addr[0];
            end
            DM_W: begin
                size = 65'd4;
                bad  = |addr[1:0];
            end
            default: bad = 1'b1;
        endcase
        if (we && (ctrl == DM_BU || ctrl == DM_HU)) begin
            bad = 1'b1;
        end
        if (({1'b0, addr} + size) > 65'(mem_bytes)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_arb2
// Description : Two-way round-robin grant. When both requesters are valid the
//               priority flop picks the winner; after every grant the priority
//               moves to the other requester.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               en_i          - grant allowed this cycle
//               req_i[1:0]    - request per requester
//               gnt_valid_o   - a grant is issued this cycle
//               gnt_idx_o     - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_valid_o = en_i & (|req_i);
        // A lone requester wins outright; only a tie consults the priority.
        if (req_i == 2'b11) begin
            gnt_idx_o = prio_q;
        end else begin
            gnt_idx_o = req_i[1];
        end
        prio_d = prio_q;
        if (gnt_valid_o) begin
            prio_d = ~gnt_idx_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbiter/sequencer sharing one combinational-read data_memory
//               between the core load/store path (port 0) and the DMA/loader
//               (port 1). One transaction at a time: accept in IDLE, present
//               the response in RESP until the owner takes it.
// Ports       : clk, rst_n               - clock, async active-low reset
//               pX_req_valid/ready/addr/wdata/we/ctrl - request channel, X=0,1
//               pX_rsp_valid/ready/rdata/err          - response channel
//               mem_address/datawr/dmwr/dmctrl        - to data_memory
//               mem_datard                            - from data_memory
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic              p0_req_we,
    input  logic [2:0]        p0_req_ctrl,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic              p1_req_we,
    input  logic [2:0]        p1_req_ctrl,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic [31:0]       mem_address,
    output logic [31:0]       mem_datawr,
    output logic              mem_dmwr,
    output logic [2:0]        mem_dmctrl,
    input  logic [31:0]       mem_datard
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              w_idle;
    logic              w_accept;
    logic              w_gnt_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic [2:0]        w_ctrl;
    logic              w_err;
    logic              w_rsp_ready;

    // Grants are suppressed while reset is held so a requester never sees a
    // handshake (or memory sees a write) that the flops cannot record.
    assign w_idle = (state_q == ST_IDLE) & rst_n;

    dmem_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (w_idle),
        .req_i       ({p1_req_valid, p0_req_valid}),
        .gnt_valid_o (w_accept),
        .gnt_idx_o   (w_gnt_idx)
    );

    // Winner's request fields.
    always_comb begin
        if (w_gnt_idx) begin
            w_addr  = p1_req_addr;
            w_wdata = p1_req_wdata;
            w_we    = p1_req_we;
            w_ctrl  = p1_req_ctrl;
        end else begin
            w_addr  = p0_req_addr;
            w_wdata = p0_req_wdata;
            w_we    = p0_req_we;
            w_ctrl  = p0_req_ctrl;
        end
    end

    assign w_err = dm_access_err(64'(w_addr), w_ctrl, w_we, MEM_BYTES);

    assign p0_req_ready = w_accept & ~w_gnt_idx;
    assign p1_req_ready = w_accept &  w_gnt_idx;

    // The memory bus carries the winner only during the accept cycle and idles
    // at a harmless word read otherwise.
    always_comb begin
        if (w_accept) begin
            mem_address = 32'(w_addr);
            mem_datawr  = 32'(w_wdata);
            mem_dmctrl  = w_ctrl;
            mem_dmwr    = w_we & ~w_err;
        end else begin
            mem_address = 32'd0;
            mem_datawr  = 32'd0;
            mem_dmctrl  = DM_W;
            mem_dmwr    = 1'b0;
        end
    end

    assign w_rsp_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_RESP;
                    owner_d = w_gnt_idx;
                    rdata_d = (w_we || w_err) ? '0 : DATA_W'(mem_datard);
                    err_d   = w_err;
                end
            end
            ST_RESP: begin
                if (w_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response valid is the RESP state itself, routed to the owner only.
    assign p0_rsp_valid = (state_q == ST_RESP) & ~owner_q;
    assign p1_rsp_valid = (state_q == ST_RESP) &  owner_q;
    assign p0_rsp_rdata = owner_q ? '0 : rdata_q;
    assign p1_rsp_rdata = owner_q ? rdata_q : '0;
    assign p0_rsp_err   = ~owner_q & err_q;
    assign p1_rsp_err   =  owner_q & err_q;

endmodule
`default_nettype wire
